udp_rx_parser: RTL and testbench

- Receive-side Ethernet/IPv4/UDP frame parser. Takes the byte stream from the RGMII nibble assembler (preamble and SFD included) and emits UDP payload as an 8-bit AXI-Stream.
- Sits between the RGMII receive PHY adapter and the receive FIFO of the UDP-over-RGMII stack, mirroring the UDP transmit framer.
- Filters frames by destination MAC, IP and port. Verifies FCS and flags the frame result on the last payload byte.

---
 rtl/udp_rx_parser_if.sv | 9 +
 rtl/udp_rx_parser.sv | 137 +++++++++++++
 tb/tb_udp_rx_parser.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/udp_rx_parser_if.sv
// udp_rx_parser_if: 8-bit AXI-Stream payload bus (no tready, sink always accepts)
interface udp_rx_parser_if #(parameter int W = 8);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tuser;
  modport master (output tdata, tvalid, tlast, tuser);
  modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/udp_rx_parser.sv
// udp_rx_parser: Ethernet/IPv4/UDP receive parser emitting filtered UDP payload with FCS status
module udp_rx_parser #(
  parameter int PAYLOAD_WIDTH = 11,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_valid_i,
  input  logic                  check_destination_i,
  input  logic [47:0]           fpga_mac_i,
  input  logic [31:0]           fpga_ip_i,
  input  logic [15:0]           fpga_port_i,
  udp_rx_parser_if.master       m_axis,
  output logic [31:0]           src_ip_o,
  output logic [15:0]           src_port_o,
  output logic                  crc_err_o,
  output logic                  frame_drop_o
);
  typedef enum logic [2:0] {WAIT_GAP, IDLE, PREAMBLE, HEADER, PAYLOAD, TRAILER, DROP} state_t;
  state_t r_state, w_next;
  logic [5:0]               r_idx;
  logic [31:0]              r_crc;
  logic [47:0]              r_dmac;
  logic [15:0]              r_etype, r_sport, r_dport, r_ulen;
  logic [7:0]               r_vihl, r_proto;
  logic [31:0]              r_sip, r_dip;
  logic [PAYLOAD_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0]    r_hold, r_tdata;
  logic                     r_hold_full, r_tvalid, r_tlast, r_tuser, r_crc_err, r_drop;
  logic [31:0]              r_src_ip;
  logic [15:0]              r_src_port;
  logic                     w_accept, w_crc_bad;
  logic [PAYLOAD_WIDTH-1:0] w_plen;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) x = x[0] ? (x >> 1) ^ 32'hEDB88320 : x >> 1;
    return x;
  endfunction

  assign w_plen    = PAYLOAD_WIDTH'(r_ulen - 16'd8);
  assign w_crc_bad = r_crc != 32'hDEBB20E3;
  assign w_accept  = r_etype == 16'h0800 && r_vihl == 8'h45 && r_proto == 8'd17 && r_ulen >= 16'd8 &&
                     (!check_destination_i || ((r_dmac == fpga_mac_i || &r_dmac) &&
                      r_dip == fpga_ip_i && r_dport == fpga_port_i));

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign m_axis.tuser  = r_tuser;
  assign src_ip_o      = r_src_ip;
  assign src_port_o    = r_src_port;
  assign crc_err_o     = r_crc_err;
  assign frame_drop_o  = r_drop;

  // state register; reset lands in WAIT_GAP so a frame already in flight is never parsed
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= WAIT_GAP;
    else       r_state <= w_next;

  // next-state decode from the incoming byte and the header decision at byte 41
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_GAP: w_next = rx_valid_i ? WAIT_GAP : IDLE;
      IDLE:     w_next = !rx_valid_i ? IDLE : rx_data_i == 8'h55 ? PREAMBLE : DROP;
      PREAMBLE: w_next = !rx_valid_i ? IDLE : rx_data_i == 8'hD5 ? HEADER :
                         rx_data_i == 8'h55 ? PREAMBLE : DROP;
      HEADER:   w_next = !rx_valid_i ? IDLE : r_idx != 6'd41 ? HEADER : !w_accept ? DROP :
                         w_plen == '0 ? TRAILER : PAYLOAD;
      PAYLOAD:  w_next = !rx_valid_i ? IDLE : r_cnt == PAYLOAD_WIDTH'(1) ? TRAILER : PAYLOAD;
      TRAILER:  w_next = rx_valid_i ? TRAILER : IDLE;
      DROP:     w_next = rx_valid_i ? DROP : IDLE;
      default:  w_next = WAIT_GAP;
    endcase
  end

  // header capture, CRC, payload hold-and-forward and one-cycle status pulses
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_idx <= '0; r_crc <= '1; r_dmac <= '0; r_etype <= '0; r_vihl <= '0; r_proto <= '0;
      r_sip <= '0; r_dip <= '0; r_sport <= '0; r_dport <= '0; r_ulen <= '0; r_cnt <= '0;
      r_hold <= '0; r_hold_full <= 1'b0; r_tdata <= '0; r_tvalid <= 1'b0; r_tlast <= 1'b0;
      r_tuser <= 1'b0; r_crc_err <= 1'b0; r_drop <= 1'b0; r_src_ip <= '0; r_src_port <= '0;
    end else begin
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tuser   <= 1'b0;
      r_crc_err <= 1'b0;
      r_drop    <= 1'b0;
      if (r_state == PREAMBLE && rx_valid_i && rx_data_i == 8'hD5) begin
        r_crc       <= '1;
        r_idx       <= '0;
        r_hold_full <= 1'b0;
      end
      if (rx_valid_i && (r_state == HEADER || r_state == PAYLOAD || r_state == TRAILER))
        r_crc <= crc_next(r_crc, rx_data_i);
      if (r_state == HEADER && !rx_valid_i) r_drop <= 1'b1;
      if (r_state == HEADER && rx_valid_i) begin
        r_idx <= r_idx + 6'd1;
        if (r_idx < 6'd6) r_dmac <= {r_dmac[39:0], rx_data_i};
        if (r_idx inside {[6'd12:6'd13]}) r_etype <= {r_etype[7:0], rx_data_i};
        if (r_idx == 6'd14) r_vihl <= rx_data_i;
        if (r_idx == 6'd23) r_proto <= rx_data_i;
        if (r_idx inside {[6'd26:6'd29]}) r_sip <= {r_sip[23:0], rx_data_i};
        if (r_idx inside {[6'd30:6'd33]}) r_dip <= {r_dip[23:0], rx_data_i};
        if (r_idx inside {[6'd34:6'd35]}) r_sport <= {r_sport[7:0], rx_data_i};
        if (r_idx inside {[6'd36:6'd37]}) r_dport <= {r_dport[7:0], rx_data_i};
        if (r_idx inside {[6'd38:6'd39]}) r_ulen <= {r_ulen[7:0], rx_data_i};
        if (r_idx == 6'd41 && !w_accept) r_drop <= 1'b1;
        if (r_idx == 6'd41 && w_accept) begin
          r_src_ip   <= r_sip;
          r_src_port <= r_sport;
          r_cnt      <= w_plen;
        end
      end
      if (r_state == PAYLOAD) begin
        r_tvalid    <= r_hold_full;
        r_tdata     <= r_hold;
        r_tlast     <= r_hold_full & !rx_valid_i;
        r_tuser     <= r_hold_full & !rx_valid_i;
        r_hold      <= rx_valid_i ? rx_data_i : r_hold;
        r_hold_full <= rx_valid_i;
        r_cnt       <= rx_valid_i ? r_cnt - PAYLOAD_WIDTH'(1) : r_cnt;
      end
      if (r_state == TRAILER && !rx_valid_i) begin
        r_tvalid    <= r_hold_full;
        r_tdata     <= r_hold;
        r_tlast     <= r_hold_full;
        r_tuser     <= r_hold_full & w_crc_bad;
        r_crc_err   <= w_crc_bad;
        r_hold_full <= 1'b0;
      end
    end
endmodule

// File: tb/tb_udp_rx_parser.sv
// tb_udp_rx_parser: directed frames against a beat scoreboard and pulse counters
module tb_udp_rx_parser;
  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0, check_destination_i = 1'b1;
  logic [47:0] fpga_mac_i = 48'he86a64e7e830;
  logic [31:0] fpga_ip_i = 32'h0A0000F0;
  logic [15:0] fpga_port_i = 16'd17767;
  logic [31:0] src_ip_o;
  logic [15:0] src_port_o;
  logic        crc_err_o, frame_drop_o;
  int          checks = 0, failures = 0, n_crc = 0, n_drop = 0, c0, d0;

  typedef struct packed {logic [7:0] d; logic l; logic u; logic c;} beat_t;
  beat_t       sb[$];
  logic [7:0]  frm[$];

  udp_rx_parser_if m_axis ();
  udp_rx_parser dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .check_destination_i(check_destination_i), .fpga_mac_i(fpga_mac_i), .fpga_ip_i(fpga_ip_i),
    .fpga_port_i(fpga_port_i), .m_axis(m_axis), .src_ip_o(src_ip_o), .src_port_o(src_port_o),
    .crc_err_o(crc_err_o), .frame_drop_o(frame_drop_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) x = x[0] ? (x >> 1) ^ 32'hEDB88320 : x >> 1;
    return x;
  endfunction

  task automatic build(input logic [15:0] dport, input int ulen, input bit flip);
    logic [7:0]  hdr[$];
    logic [31:0] c;
    logic [15:0] tot;
    int          pad;
    tot = 16'(20 + ulen);
    pad = (46 - (20 + ulen)) > 0 ? 46 - (20 + ulen) : 0;
    hdr = {8'he8, 8'h6a, 8'h64, 8'he7, 8'he8, 8'h30, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
           8'h08, 8'h00, 8'h45, 8'h00, tot[15:8], tot[7:0], 8'h00, 8'h00, 8'h40, 8'h00,
           8'h40, 8'h11, 8'h00, 8'h00, 8'h0a, 8'h00, 8'h00, 8'h0a, 8'h0a, 8'h00, 8'h00, 8'hf0,
           8'h45, 8'h67, dport[15:8], dport[7:0], 8'(ulen >> 8), 8'(ulen), 8'h00, 8'h00};
    frm.delete();
    for (int i = 0; i < 7; i++) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    foreach (hdr[i]) frm.push_back(hdr[i]);
    for (int i = 0; i < ulen - 8; i++) frm.push_back(8'(i));
    for (int i = 0; i < pad; i++) frm.push_back(8'h00);
    c = '1;
    for (int i = 8; i < frm.size(); i++) c = crc8(c, frm[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    if (flip) frm[55] = frm[55] ^ 8'h10;
  endtask

  task automatic expect_beats(input int n, input bit user_last, input bit crc_last);
    for (int i = 0; i < n; i++)
      sb.push_back('{d: frm[50 + i], l: i == n - 1, u: i == n - 1 && user_last, c: i == n - 1 && crc_last});
  endtask

  task automatic send(input int nbytes, input int gap, input int rst_at);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk_i);
      rx_valid_i = 1'b1;
      rx_data_i  = frm[i];
      if (i == rst_at) begin
        #2 rst_i = 1'b1;
        #1;
        chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
        chk("rst_src_ip", 64'(src_ip_o), 64'd0);
        chk("rst_src_port", 64'(src_port_o), 64'd0);
      end
      if (i == rst_at + 3) rst_i = 1'b0;
    end
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    rx_data_i  = '0;
    repeat (gap) @(negedge clk_i);
  endtask

  task automatic snap();
    c0 = n_crc;
    d0 = n_drop;
  endtask

  task automatic done(input string tag, input int crc_exp, input int drop_exp);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    chk({tag, "_crc_pulses"}, 64'(n_crc - c0), 64'(crc_exp));
    chk({tag, "_drop_pulses"}, 64'(n_drop - d0), 64'(drop_exp));
    sb.delete();
  endtask

  // beat monitor: sample away from the rising edge and pop expectations in order
  always @(negedge clk_i) begin
    if (crc_err_o) n_crc++;
    if (frame_drop_o) n_drop++;
    if (m_axis.tvalid) begin
      chk("beat_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        beat_t e;
        e = sb.pop_front();
        chk("tdata", 64'(m_axis.tdata), 64'(e.d));
        chk("tlast", 64'(m_axis.tlast), 64'(e.l));
        chk("tuser", 64'(m_axis.tuser), 64'(e.u));
        chk("crc_err_align", 64'(crc_err_o), 64'(e.c));
      end
    end
  end

  initial begin
    #1 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("reset_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("reset_tlast", 64'(m_axis.tlast), 64'd0);
    chk("reset_tuser", 64'(m_axis.tuser), 64'd0);
    chk("reset_src_ip", 64'(src_ip_o), 64'd0);
    chk("reset_src_port", 64'(src_port_o), 64'd0);
    chk("reset_pulses", 64'({crc_err_o, frame_drop_o}), 64'd0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);

    build(16'd17767, 348, 1'b0); snap(); expect_beats(340, 1'b0, 1'b0); send(frm.size(), 12, -1);
    done("good", 0, 0);
    chk("src_ip", 64'(src_ip_o), 64'h0A00000A);
    chk("src_port", 64'(src_port_o), 64'd17767);

    build(16'd17767, 348, 1'b1); snap(); expect_beats(340, 1'b1, 1'b1); send(frm.size(), 12, -1);
    done("badfcs", 1, 0);

    build(16'd1234, 348, 1'b0); snap(); send(frm.size(), 12, -1);
    done("port_filter", 0, 1);

    check_destination_i = 1'b0;
    build(16'd1234, 348, 1'b0); snap(); expect_beats(340, 1'b0, 1'b0); send(frm.size(), 12, -1);
    done("no_filter", 0, 0);
    check_destination_i = 1'b1;

    build(16'd17767, 10, 1'b0); snap(); expect_beats(2, 1'b0, 1'b0); send(frm.size(), 12, -1);
    done("short_pad", 0, 0);
    chk("short_frame_len", 64'(frm.size()), 64'd72);

    build(16'd17767, 348, 1'b0); snap(); expect_beats(100, 1'b1, 1'b0); send(150, 0, -1);
    expect_beats(340, 1'b0, 1'b0); send(frm.size(), 12, -1);
    done("trunc_then_good", 0, 0);

    build(16'd17767, 348, 1'b0); snap(); expect_beats(49, 1'b0, 1'b0); sb[48].l = 1'b0;
    send(frm.size(), 12, 100);
    done("reset_mid", 0, 0);
    chk("reset_mid_src_ip", 64'(src_ip_o), 64'd0);
    snap(); expect_beats(340, 1'b0, 1'b0); send(frm.size(), 12, -1);
    done("after_reset", 0, 0);
    chk("after_reset_src_ip", 64'(src_ip_o), 64'h0A00000A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
